// File: rtl/exu_alu_core.sv
// exu_alu_core: execute-stage ALU with valid/ready handshake on both sides.
// Single-cycle ops: ADD, SUB, EQ, NE, LESS_U, NO_FUNC (undefined codes -> 0).
// Optional feature macro ALU_SHIFT_EN: adds SLL/SRL/SRA as a 1-bit-per-cycle
// iterative shifter (BUSY state + shift counter). Without it, shift codes
// behave like NO_FUNC.
// Function encoding (alu_func): NO_FUNC=0 ADD=1 SUB=2 EQ=3 NE=4 LESS_U=5
//                               SLL=6 SRL=7 SRA=8
module exu_alu_core #(
  parameter int DATA_W  = 32,
  parameter int FUNC_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [FUNC_W-1:0] alu_func,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              cmp,
  output logic              busy
);

  localparam logic [FUNC_W-1:0] F_NO_FUNC = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] F_ADD     = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] F_SUB     = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] F_EQ      = FUNC_W'(3);
  localparam logic [FUNC_W-1:0] F_NE      = FUNC_W'(4);
  localparam logic [FUNC_W-1:0] F_LESS_U  = FUNC_W'(5);
  localparam logic [FUNC_W-1:0] F_SLL     = FUNC_W'(6);
  localparam logic [FUNC_W-1:0] F_SRL     = FUNC_W'(7);
  localparam logic [FUNC_W-1:0] F_SRA     = FUNC_W'(8);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] alu_res;
  logic              accept;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cmp       = result_q[0];

`ifdef ALU_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;

  assign shamt    = alu_b[SHAMT_W-1:0];
  assign is_shift = (alu_func == F_SLL) | (alu_func == F_SRL) | (alu_func == F_SRA);
`else
  // Shift amount has no consumer when the shifter is compiled out.
  logic unused_shamt;
  assign unused_shamt = ^alu_b[SHAMT_W-1:0];
`endif

  // Single-cycle result; a shift by zero simply passes operand A through.
  always_comb begin
    alu_res = '0;
    case (alu_func)
      F_ADD:    alu_res = alu_a + alu_b;
      F_SUB:    alu_res = alu_a - alu_b;
      F_EQ:     alu_res = DATA_W'(alu_a == alu_b);
      F_NE:     alu_res = DATA_W'(alu_a != alu_b);
      F_LESS_U: alu_res = DATA_W'(alu_a < alu_b);
`ifdef ALU_SHIFT_EN
      F_SLL, F_SRL, F_SRA: alu_res = alu_a;
`else
      F_SLL, F_SRL, F_SRA: alu_res = '0;
`endif
      F_NO_FUNC: alu_res = '0;
      default:  alu_res = '0;
    endcase
  end

  // Next-state logic: accept in IDLE, iterate in BUSY, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
`ifdef ALU_SHIFT_EN
    cnt_d    = cnt_q;
    func_d   = func_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          result_d = alu_res;
          state_d  = DONE;
`ifdef ALU_SHIFT_EN
          if (is_shift && (shamt != '0)) begin
            cnt_d   = shamt;
            func_d  = alu_func;
            state_d = BUSY;
          end
`endif
        end
      end
      BUSY: begin
`ifdef ALU_SHIFT_EN
        // Shift while the counter is non-zero; one extra cycle at zero to finish.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (func_q)
            F_SLL:   result_d = {result_q[DATA_W-2:0], 1'b0};
            F_SRA:   result_d = {result_q[DATA_W-1], result_q[DATA_W-1:1]};
            default: result_d = {1'b0, result_q[DATA_W-1:1]};
          endcase
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
`ifdef ALU_SHIFT_EN
      cnt_q    <= '0;
      func_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
`ifdef ALU_SHIFT_EN
      cnt_q    <= cnt_d;
      func_q   <= func_d;
`endif
    end
  end

endmodule
